pipelined_logic_unit: RTL and testbench

//   Parametrised successor to the lab's single-bit gate cells: a WIDTH-bit bitwise

---
 rtl/pipelined_logic_unit.sv | 88 ++++++++
 tb/tb_pipelined_logic_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_logic_unit.sv
// rtl/pipelined_logic_unit.sv - two-stage valid/ready bitwise logic unit with zero flag and transfer counter
module pipelined_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_res;
    logic             s2_adv;

    // S2 can take a new item when it is empty or its item leaves this cycle;
    // S1 can take one when it is empty or it can hand its item to S2.
    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;

    // Result is formed from the S1 registers so S2 only ever stores settled values.
    always_comb begin
        s1_res = '0;
        case (s1_op)
            3'd0:    s1_res = ~(s1_a & s1_b);
            3'd1:    s1_res = s1_a & s1_b;
            3'd2:    s1_res = s1_a | s1_b;
            3'd3:    s1_res = ~(s1_a | s1_b);
            3'd4:    s1_res = s1_a ^ s1_b;
            3'd5:    s1_res = ~(s1_a ^ s1_b);
            3'd6:    s1_res = ~s1_a;
            default: s1_res[0] = ~(&s1_a);
        endcase
    end

    // Stage 1: capture operands; data only moves on valid cycles so X inputs never enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    // Stage 2: registered result and zero flag, held while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            zero      <= 1'b1;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                o    <= s1_res;
                zero <= (s1_res == '0);
            end
        end
    end

    // Completed output transfers, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (out_valid && out_ready) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb/tb_pipelined_logic_unit.sv - self-checking bench for pipelined_logic_unit
module tb_pipelined_logic_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] o;
    logic       zero;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_logic_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .zero(zero), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] k);
        case (k)
            3'd0:    return 8'hFF ^ (x & y);
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return 8'hFF ^ (x | y);
            3'd4:    return x ^ y;
            3'd5:    return 8'hFF ^ x ^ y;
            3'd6:    return 8'hFF - x;
            default: return (x == 8'hFF) ? 8'h00 : 8'h01;
        endcase
    endfunction

    // Model: queue of accepted items with acceptance cycle stamps
    logic [7:0] exp_q[$];
    int         stamp_q[$];
    logic [7:0] out_log[$];
    logic       zero_log[$];
    int         cyc = 0;
    int         acc_total = 0;
    logic [3:0] cnt_exp = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_o = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic ov_e;
        if (!rst_n) begin
            exp_q.delete();
            stamp_q.delete();
            cnt_exp = '0;
            prev_stall = 1'b0;
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_o", o, 8'h00);
            chk("rst_zero", zero, 1'b1);
            chk("rst_count", count, 4'h0);
            chk("rst_in_ready", in_ready, 1'b1);
        end else begin
            ov_e = 1'b0;
            if (exp_q.size() > 0) ov_e = (cyc - stamp_q[0]) >= 2;
            chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            chk("out_valid", out_valid, ov_e);
            chk("count", count, cnt_exp);
            if (prev_stall) chk("stall_hold", o, prev_o);
            if (out_valid && exp_q.size() > 0) begin
                chk("o", o, exp_q[0]);
                chk("zero", zero, exp_q[0] == 8'h00);
            end
            if (out_valid && out_ready) begin
                out_log.push_back(o);
                zero_log.push_back(zero);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(stamp_q.pop_front());
                end
                cnt_exp++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(a, b, op));
                stamp_q.push_back(cyc);
                acc_total++;
            end
            prev_stall = out_valid && !out_ready;
            prev_o = o;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        op = 'x;
    endtask

    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xop);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        op = xop;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    logic [7:0] lit_o[9]    = '{8'hF0, 8'h24, 8'hBD, 8'h42, 8'h99, 8'h66, 8'h5A, 8'h00, 8'h01};
    logic       lit_zero[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        idle();
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: NAND with latency
        send(8'hFF, 8'h0F, 3'd0);
        @(negedge clk);
        chk("t1_lat_early", out_valid, 1'b0);
        @(negedge clk);
        chk("t1_lat_valid", out_valid, 1'b1);
        chk("t1_o", o, 8'hF0);
        chk("t1_zero", zero, 1'b0);
        @(posedge clk);
        #1;

        // 2: OP sweep back-to-back
        for (int i = 1; i <= 6; i++) send(8'hA5, 8'h3C, 3'(i));
        // 3: reduce-NAND
        send(8'hFF, 8'h00, 3'd7);
        send(8'hFE, 8'h00, 3'd7);
        drain();
        chk("log_size", out_log.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < out_log.size()) begin
                chk($sformatf("lit_o_%0d", i), out_log[i], lit_o[i]);
                chk($sformatf("lit_zero_%0d", i), zero_log[i], lit_zero[i]);
            end
        end

        // 4: backpressure with continuous input
        base = out_log.size();
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a = 8'h10 + 8'(k);
            b = 8'h33;
            op = 3'(k);
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk);
            #1;
        end
        chk("t4_accepts", k, 2);
        chk("t4_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int j = k; j < 6; j++) send(8'h10 + 8'(j), 8'h33, 3'(j));
        drain();
        chk("t4_delivered", out_log.size() - base, 6);
        if (out_log.size() >= base + 2) begin
            chk("t4_first", out_log[base], 8'hEF);
            chk("t4_second", out_log[base + 1], 8'h11);
        end

        // 5: counter wrap at 16
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 17; j++) send(8'(j * 13), 8'(j * 7), 3'(j));
        drain();
        chk("t5_count_wrap", count, 4'd1);

        // 6: reset with both stages full
        out_ready = 1'b0;
        send(8'h12, 8'h34, 3'd2);
        send(8'h56, 8'h78, 3'd4);
        chk("t6_full_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_o", o, 8'h00);
        chk("t6_zero", zero, 1'b1);
        chk("t6_count", count, 4'd0);
        chk("t6_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'hC3, 8'h0F, 3'd1);
        @(negedge clk);
        chk("t6_lat_early", out_valid, 1'b0);
        @(negedge clk);
        chk("t6_lat_valid", out_valid, 1'b1);
        chk("t6_post_o", o, 8'h03);
        drain();
        @(posedge clk);
        #1;
        chk("t6_post_count", count, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
